// File: rtl/quad_input_filter.sv
// Quadrature front end: synchronise, debounce and Gray-decode QA/QB into step/dir/err pulses.
// Optional macro QUAD_FILT_ERR_CNT_EN enables the saturating err_count; otherwise it is tied to 0.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 16,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 qa_raw,
  input  logic                 qb_raw,
  input  logic                 en,
  output logic                 qa,
  output logic                 qb,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [8:0] PRIME_LAST = 9'(SYNC_STAGES + FILT_CYCLES - 1);
  localparam logic [7:0] FILT_LAST  = 8'(FILT_CYCLES - 1);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [7:0]             cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [8:0]             prime_q, prime_d;
  logic                   qa_q, qa_d, qb_q, qb_d;
  logic                   step_q, step_d, dir_q, dir_d, err_q, err_d;
  state_t                 state_q, state_d;
  logic                   active_s, sa_s, sb_s;
`ifdef QUAD_FILT_ERR_CNT_EN
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
`endif

  // Returns {next filtered level, next counter}: a change commits only after FILT_CYCLES differing samples.
  function automatic logic [8:0] filt_next(input logic synced, input logic filt, input logic [7:0] cnt);
    if (synced == filt) begin
      return {filt, 8'd0};
    end else if (cnt == FILT_LAST) begin
      return {synced, 8'd0};
    end else begin
      return {filt, cnt + 8'd1};
    end
  endfunction

  assign sa_s     = sync_a_q[SYNC_STAGES-1];
  assign sb_s     = sync_b_q[SYNC_STAGES-1];
  assign active_s = (state_q == RUN) && en;

  // Next-state logic: synchronisers, filters, decode and prime sequencing.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], qa_raw};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], qb_raw};
    step_d   = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    state_d  = state_q;
    prime_d  = prime_q;
`ifdef QUAD_FILT_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
`endif

    // Outside RUN the filtered levels track the synchronisers so RUN starts from the live input.
    if (active_s) begin
      {qa_d, cnt_a_d} = filt_next(sa_s, qa_q, cnt_a_q);
      {qb_d, cnt_b_d} = filt_next(sb_s, qb_q, cnt_b_q);
    end else begin
      qa_d    = sa_s;
      qb_d    = sb_s;
      cnt_a_d = 8'd0;
      cnt_b_d = 8'd0;
    end

    if (active_s) begin
      case ({qa_d ^ qa_q, qb_d ^ qb_q})
        2'b01, 2'b10: begin
          step_d = 1'b1;
          dir_d  = qa_d ^ qb_q;
        end
        2'b11: begin
          err_d = 1'b1;
`ifdef QUAD_FILT_ERR_CNT_EN
          if (err_cnt_q != {ERR_WIDTH{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
          end else begin
            err_cnt_d = err_cnt_q;
          end
`endif
        end
        default: begin
          step_d = 1'b0;
          err_d  = 1'b0;
        end
      endcase
    end else begin
      step_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      PRIME: begin
        if (prime_q == PRIME_LAST) begin
          state_d = en ? RUN : PRIME;
        end else begin
          prime_d = prime_q + 9'd1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = PRIME;
          prime_d = 9'd0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = PRIME;
        prime_d = 9'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_a_q  <= {SYNC_STAGES{1'b0}};
      sync_b_q  <= {SYNC_STAGES{1'b0}};
      cnt_a_q   <= 8'd0;
      cnt_b_q   <= 8'd0;
      prime_q   <= 9'd0;
      qa_q      <= 1'b0;
      qb_q      <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= PRIME;
`ifdef QUAD_FILT_ERR_CNT_EN
      err_cnt_q <= {ERR_WIDTH{1'b0}};
`endif
    end else begin
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      prime_q   <= prime_d;
      qa_q      <= qa_d;
      qb_q      <= qb_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      state_q   <= state_d;
`ifdef QUAD_FILT_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign qa   = qa_q;
  assign qb   = qb_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;
`ifdef QUAD_FILT_ERR_CNT_EN
  assign err_count = err_cnt_q;
`else
  assign err_count = {ERR_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter: table of held input levels plus hand sequences for
// latency, glitch rejection, enable drop and mid-operation reset.
module tb_quad_input_filter;

  localparam int EW     = 2;
  localparam int EC_MAX = 3;

  logic          clk = 1'b0;
  logic          resetn, qa_raw, qb_raw, en;
  logic          qa, qb, step, dir, err;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int step_tot = 0;
  int err_tot = 0;
  int exp_ec = 0;
  int s0, e0, lat;

  typedef struct {
    logic a;
    logic b;
    int   hold;
    logic exp_qa;
    logic exp_qb;
    int   exp_steps;
    int   exp_errs;
    logic exp_dir;
  } vec_t;

  vec_t vecs[14];

  quad_input_filter #(.SYNC_STAGES(2), .FILT_CYCLES(16), .ERR_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .qa_raw(qa_raw), .qb_raw(qb_raw), .en(en),
    .qa(qa), .qb(qb), .step(step), .dir(dir), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step) step_tot = step_tot + 1;
    if (err) err_tot = err_tot + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bump_ec();
`ifdef QUAD_FILT_ERR_CNT_EN
    if (exp_ec < EC_MAX) exp_ec = exp_ec + 1;
`else
    exp_ec = 0;
`endif
  endtask

  initial begin
    // Up rotation from 11, down rotation, five double transitions, then one legal step.
    vecs[0]  = '{1'b0, 1'b1, 40, 1'b0, 1'b1, 1, 0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1, 0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 40, 1'b1, 1'b0, 1, 0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 40, 1'b1, 1'b1, 1, 0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 40, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 40, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 40, 1'b1, 1'b1, 1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 40, 1'b1, 1'b1, 0, 1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 40, 1'b1, 1'b1, 0, 1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 40, 1'b1, 1'b0, 1, 0, 1'b1};

    resetn = 1'b0; qa_raw = 1'b1; qb_raw = 1'b1; en = 1'b1;
    cycles(3);
    check("reset qa", qa, 0);
    check("reset qb", qb, 0);
    check("reset step", step, 0);
    check("reset dir", dir, 0);
    check("reset err", err, 0);
    check("reset err_count", err_count, 0);

    resetn = 1'b1;
    s0 = step_tot; e0 = err_tot;
    cycles(18);
    check("prime qa", qa, 1);
    check("prime qb", qb, 1);
    check("prime state run", int'(dut.state_q), 1);
    check("prime steps", step_tot - s0, 0);
    check("prime errs", err_tot - e0, 0);

    for (int i = 0; i < 14; i++) begin
      s0 = step_tot; e0 = err_tot;
      qa_raw = vecs[i].a; qb_raw = vecs[i].b;
      cycles(vecs[i].hold);
      if (vecs[i].exp_errs != 0) bump_ec();
      check($sformatf("row%0d qa", i), qa, vecs[i].exp_qa);
      check($sformatf("row%0d qb", i), qb, vecs[i].exp_qb);
      check($sformatf("row%0d steps", i), step_tot - s0, vecs[i].exp_steps);
      check($sformatf("row%0d errs", i), err_tot - e0, vecs[i].exp_errs);
      check($sformatf("row%0d dir", i), dir, vecs[i].exp_dir);
      check($sformatf("row%0d err_count", i), err_count, exp_ec);
    end

    // Latency: qb edge driven before edge 1 steps on edge SYNC_STAGES+FILT_CYCLES = 18.
    lat = 0;
    s0 = step_tot;
    qb_raw = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (step && lat == 0) lat = c;
    end
    check("latency cycles", lat, 18);
    check("latency steps", step_tot - s0, 1);
    check("latency dir", dir, 1);
    check("latency qb", qb, 1);

    // 11 -> 01 then a 10-cycle qa glitch that must be swallowed.
    qa_raw = 1'b0;
    cycles(40);
    check("to01 qa", qa, 0);
    check("to01 dir", dir, 1);
    s0 = step_tot;
    qa_raw = 1'b1;
    cycles(10);
    qa_raw = 1'b0;
    cycles(30);
    check("glitch qa", qa, 0);
    check("glitch steps", step_tot - s0, 0);
    check("glitch cnt", int'(dut.cnt_a_q), 0);

    // Enable drop with input activity, then reassert and step normally.
    s0 = step_tot; e0 = err_tot;
    en = 1'b0;
    cycles(10);
    qa_raw = 1'b1;
    cycles(20);
    qb_raw = 1'b0;
    cycles(20);
    en = 1'b1;
    cycles(20);
    check("endrop steps", step_tot - s0, 0);
    check("endrop errs", err_tot - e0, 0);
    check("endrop qa", qa, 1);
    check("endrop qb", qb, 0);
    s0 = step_tot;
    qb_raw = 1'b1;
    cycles(40);
    check("resume steps", step_tot - s0, 1);
    check("resume dir", dir, 1);
    check("resume qb", qb, 1);

    // Reset lands on the edge where the pending qb change would have stepped.
    s0 = step_tot; e0 = err_tot;
    qb_raw = 1'b0;
    cycles(16);
    resetn = 1'b0;
    cycles(3);
    exp_ec = 0;
    check("midrst steps", step_tot - s0, 0);
    check("midrst errs", err_tot - e0, 0);
    check("midrst qa", qa, 0);
    check("midrst dir", dir, 0);
    check("midrst err_count", err_count, exp_ec);
    resetn = 1'b1;
    cycles(30);
    check("postrst qa", qa, 1);
    check("postrst qb", qb, 0);
    check("postrst steps", step_tot - s0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_input_filter.md
Name: quad_input_filter

Overview:
- Front-end conditioning stage for the rotary quadrature decoder: sits between the QA/QB pad inputs and the decoder/counter.
- Synchronises both raw encoder channels and debounces each one with a stable-for-N-cycles filter.
- Emits clean qa/qb levels plus one-cycle step/dir pulses for each legal Gray-code transition.
- Flags illegal double transitions (both channels changing together) as errors instead of miscounting them.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- FILT_CYCLES, 16, consecutive differing samples required before a filtered output changes; legal range 1..255.
- ERR_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset: synchronous, active-low. Clock is clk.
- qa_raw  in  1  asynchronous encoder channel A from the pad.
- qb_raw  in  1  asynchronous encoder channel B from the pad.
- en  in  1  filter/decode enable.
- qa  out  1  filtered channel A.
- qb  out  1  filtered channel B.
- step  out  1  one-cycle pulse per legal transition.
- dir  out  1  direction of the last step; 1 = count up.
- err  out  1  one-cycle pulse per illegal double transition.
- err_count  out  ERR_WIDTH  saturating error total.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Clears synchroniser flops, filter counters and qa, qb, step, dir, err, err_count to 0.
  - Enters state PRIME.
- Synchroniser: SYNC_STAGES-deep shift register per channel; the filter uses only the last stage.
- Filter, per channel:
  - An 8-bit counter increments each cycle the synced value differs from the filtered output.
  - It clears to 0 whenever the two are equal.
  - When the counter would reach FILT_CYCLES, the filtered output takes the synced value and the counter clears.
  - Any return to the old level before that point discards the pending change, so glitches shorter than FILT_CYCLES are removed.
- Latency: a clean raw edge reaches qa/qb SYNC_STAGES+FILT_CYCLES edges later (+1 for asynchronous sampling).
- State machine:
  - PRIME:
    - Filtered outputs load the synced inputs directly each cycle.
    - A prime counter runs for SYNC_STAGES+FILT_CYCLES cycles.
    - step and err are held at 0.
    - Moves to RUN when the prime counter expires and en=1.
  - RUN:
    - Normal filtering and decoding.
    - en=0 returns to PRIME on the next edge; the prime counter restarts.
- Decode, in RUN only; compare the previous registered {qa,qb} with the next filtered value:
  - No change: step=0, err=0.
  - Exactly one bit changes: step=1 for one cycle, and dir is set to qa_next XOR qb_prev.
  - Both bits change in the same cycle: err=1 for one cycle, step=0, dir unchanged, and the error counter increments.
- Output timing and hold:
  - qa, qb, step, dir and err update on the same edge, so step is high in the first cycle qa/qb show the new value.
  - dir holds its value between steps.
- Error counter: saturates at 2^ERR_WIDTH-1 and never wraps.
- Reset mid-operation: pending filter changes and in-flight pulses are dropped; no step or err is produced on the reset edge.

Optional Feature:
- Macro: QUAD_FILT_ERR_CNT_EN.
- Defined: err_count is the saturating counter described above.
- Undefined: the counter logic is omitted and err_count is tied to 0; the err pulse still operates.

Test Plan:
- Hold qa_raw=qb_raw=1 through reset, en=1 → after 18 cycles qa=qb=1, state RUN, zero step and zero err pulses.
- Sequence 00→10→11→01→00, each level held 40 cycles (defaults) → exactly 4 step pulses, each with dir=1.
- Reverse sequence 00→01→11→10→00 → 4 step pulses with dir=0.
- Raw edge at cycle 0 → step pulse at cycle 18 (±1).
- qa_raw glitch high for 10 cycles → qa stays 0, no step, filter counter back to 0.
- qa_raw and qb_raw toggle 00→11 on the same cycle and hold → one err pulse, no step, err_count=1.
- With ERR_WIDTH=2, five such errors → err_count=3.
- Without QUAD_FILT_ERR_CNT_EN → err_count stays 0 while err still pulses.
- Drop en for 50 cycles during a rotation, toggling qa_raw meanwhile, then reassert → no step while en=0 or during re-prime; qa reflects the current input and the next legal transition steps normally.
